ioport_irq: RTL and testbench

- Parametrised general-purpose I/O port for the Fake6523 design, successor to the fixed 8-bit DDR/port block.
- Each bit has a direction bit (DDR) and an output latch, as before.
- Adds:
  - configurable width;
  - input synchronisers with read-back of the pins;
  - per-bit edge-detect interrupt flags with mask and selectable polarity;
  - write-1-to-clear acknowledge.
- Sits between the chip's register decoder and the external port pins; its irq output feeds the interrupt priority logic.

---
 rtl/ioport_irq_if.sv | 13 +
 rtl/ioport_irq.sv | 109 ++++++++++
 tb/tb_ioport_irq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ioport_irq_if.sv
// Register-bus bundle between the chip's register decoder and the I/O port.
// The decoder is the master; ioport_irq is the slave.
interface ioport_irq_if #(
   parameter int WIDTH = 8
) ();
   logic [2:0]       addr;
   logic             we;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;

   modport master (output addr, output we, output data_in, input data_out);
   modport slave  (input addr, input we, input data_in, output data_out);
endinterface

// File: rtl/ioport_irq.sv
// Parametrised GPIO port with direction control, synchronised pin read-back,
// per-bit edge interrupt flags (mask, polarity, write-1-to-clear) and a registered irq.
module ioport_irq #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   ioport_irq_if.slave      bus,
   inout  wire  [WIDTH-1:0] pins,
   output logic             irq
);

   localparam int PW = $clog2(SYNC_STAGES + 2);
   localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

   localparam logic [2:0] A_PORT  = 3'd0;
   localparam logic [2:0] A_DDR   = 3'd1;
   localparam logic [2:0] A_IMASK = 3'd2;
   localparam logic [2:0] A_EDGE  = 3'd3;
   localparam logic [2:0] A_IFLAG = 3'd4;
   localparam logic [2:0] A_PIN   = 3'd5;

   logic [WIDTH-1:0] port_q;
   logic [WIDTH-1:0] ddr_q;
   logic [WIDTH-1:0] imask_q;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] iflag_q;
   logic [WIDTH-1:0] hist_q;
   logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
   logic [WIDTH-1:0] sync_val;
   logic [PW-1:0]    prime_cnt;
   logic             primed;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] iflag_clr;

   assign sync_val = sync_chain[SYNC_STAGES-1];
   assign primed   = (prime_cnt == PRIME_DONE);

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin_drv
      assign pins[i] = ddr_q[i] ? port_q[i] : 1'bz;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
      end else begin
         sync_chain[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
      end
   end

   // Priming keeps the reset-zero sync chain from looking like a rising edge
   // on pins that are already high when reset releases.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         prime_cnt <= '0;
      else if (!primed)
         prime_cnt <= prime_cnt + 1'b1;
   end

   assign rise     = sync_val & ~hist_q;
   assign fall     = ~sync_val & hist_q;
   assign edge_hit = ((edge_q & rise) | (~edge_q & fall)) & ~ddr_q & {WIDTH{primed}};
   assign iflag_clr = (bus.we && bus.addr == A_IFLAG) ? bus.data_in : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         port_q  <= '0;
         ddr_q   <= '0;
         imask_q <= '0;
         edge_q  <= '0;
         iflag_q <= '0;
         hist_q  <= '0;
         irq     <= 1'b0;
      end else begin
         // History always tracks sync, so a DDR flip sees no edge on its own cycle.
         hist_q  <= sync_val;
         iflag_q <= (iflag_q & ~iflag_clr) | edge_hit;
         irq     <= |(iflag_q & imask_q);
         if (bus.we) begin
            case (bus.addr)
               A_PORT:  port_q  <= bus.data_in;
               A_DDR:   ddr_q   <= bus.data_in;
               A_IMASK: imask_q <= bus.data_in;
               A_EDGE:  edge_q  <= bus.data_in;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      bus.data_out = '0;
      case (bus.addr)
         A_PORT:  bus.data_out = (port_q & ddr_q) | (sync_val & ~ddr_q);
         A_DDR:   bus.data_out = ddr_q;
         A_IMASK: bus.data_out = imask_q;
         A_EDGE:  bus.data_out = edge_q;
         A_IFLAG: bus.data_out = iflag_q;
         A_PIN:   bus.data_out = sync_val;
         default: bus.data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_ioport_irq.sv
// Directed bench for ioport_irq: a pin-sample-history model is checked every cycle,
// plus hand-computed literal checks for the key timing points.
module tb_ioport_irq;

   localparam int W = 8;
   localparam int S = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic irq;
   wire  [W-1:0] pins;
   logic [W-1:0] ext_val = 8'hFF;
   logic [W-1:0] ext_en  = 8'hFF;

   int n_cmp = 0;
   int n_err = 0;
   bit running = 1'b0;

   ioport_irq_if #(.WIDTH(W)) bus ();

   ioport_irq #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave),
      .pins  (pins),
      .irq   (irq)
   );

   always #5 clock = ~clock;

   for (genvar i = 0; i < W; i++) begin : g_ext
      assign pins[i] = ext_en[i] ? ext_val[i] : 1'bz;
   end

   // Model state: register contents plus the history of pin values seen at each edge.
   logic [W-1:0] m_port = '0, m_ddr = '0, m_imask = '0, m_edge = '0, m_iflag = '0;
   logic         m_irq = 1'b0;
   logic [W-1:0] samp [$];
   int           m_nedge = 0;

   // External drivers release a pin once the port drives it; NBA keeps this off the sampling edge.
   always @(m_ddr) ext_en <= ~m_ddr;

   function automatic logic [W-1:0] m_sync();
      if (samp.size() >= S) return samp[samp.size()-S];
      return '0;
   endfunction

   function automatic logic [W-1:0] m_read(input logic [2:0] a);
      logic [W-1:0] sy;
      sy = m_sync();
      case (a)
         3'd0: return (m_port & m_ddr) | (sy & ~m_ddr);
         3'd1: return m_ddr;
         3'd2: return m_imask;
         3'd3: return m_edge;
         3'd4: return m_iflag;
         3'd5: return sy;
         default: return '0;
      endcase
   endfunction

   always @(posedge clock or posedge reset) begin
      logic [W-1:0] det, sy, hi, pv, clr;
      logic         irq_n;
      if (reset) begin
         m_port = '0; m_ddr = '0; m_imask = '0; m_edge = '0; m_iflag = '0;
         m_irq = 1'b0;
         samp.delete();
         m_nedge = 0;
      end else begin
         det = '0;
         if (m_nedge >= S + 1) begin
            sy = samp[samp.size()-S];
            hi = samp[samp.size()-S-1];
            for (int i = 0; i < W; i++)
               if (!m_ddr[i])
                  det[i] = m_edge[i] ? (sy[i] && !hi[i]) : (!sy[i] && hi[i]);
         end
         pv    = (m_ddr & m_port) | (~m_ddr & ext_val);
         irq_n = |(m_iflag & m_imask);
         clr   = (bus.we && bus.addr == 3'd4) ? bus.data_in : '0;
         m_iflag = (m_iflag & ~clr) | det;
         if (bus.we) begin
            case (bus.addr)
               3'd0: m_port  = bus.data_in;
               3'd1: m_ddr   = bus.data_in;
               3'd2: m_imask = bus.data_in;
               3'd3: m_edge  = bus.data_in;
               default: ;
            endcase
         end
         m_irq = irq_n;
         samp.push_back(pv);
         if (samp.size() > 12) void'(samp.pop_front());
         if (m_nedge < 100) m_nedge++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (running) begin
         chk("cyc_data_out", 32'(bus.data_out), 32'(m_read(bus.addr)));
         chk("cyc_irq", 32'(irq), 32'(m_irq));
         chk("cyc_pins", 32'(pins & m_ddr), 32'(m_port & m_ddr));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      bus.addr = a;
      bus.we = 1'b1;
      bus.data_in = d;
      @(posedge clock);
      #1;
      bus.we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [W-1:0] exp, input string nm);
      bus.addr = a;
      #1;
      chk(nm, 32'(bus.data_out), 32'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.addr = 3'd4;
      bus.we = 1'b0;
      bus.data_in = '0;
      ext_val = 8'hFF;
      tick(3);
      chk("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      running = 1'b1;

      // Pins pulled high through reset: no flags, pins read back high.
      tick(10);
      rd(3'd4, 8'h00, "boot_iflag");
      chk("boot_irq", 32'(irq), 32'h0);
      rd(3'd5, 8'hFF, "boot_pin");

      // Low nibble as outputs.
      wr(3'd1, 8'h0F);
      wr(3'd0, 8'hA5);
      chk("drv_pins_lo", 32'(pins[3:0]), 32'h5);
      rd(3'd0, 8'hF5, "port_read_mixed");
      tick(S);
      rd(3'd5, 8'hF5, "pin_read_driven");

      // Pin0 rising edge with EDGE[0]=1, IMASK[0]=1.
      ext_val = 8'hF5;
      wr(3'd1, 8'h00);
      wr(3'd3, 8'h01);
      ext_val = 8'hF4;
      tick(6);
      wr(3'd2, 8'h01);
      bus.addr = 3'd4;
      ext_val = 8'hF5;
      tick(S);
      rd(3'd4, 8'h00, "rise_flag_early");
      tick(1);
      rd(3'd4, 8'h01, "rise_flag_set");
      chk("rise_irq_lag", 32'(irq), 32'h0);
      tick(1);
      chk("rise_irq_set", 32'(irq), 32'h1);
      wr(3'd4, 8'h01);
      chk("clr_irq_hold", 32'(irq), 32'h1);
      rd(3'd4, 8'h00, "clr_flag");
      tick(1);
      chk("clr_irq_drop", 32'(irq), 32'h0);

      // Pin1 falling, masked off, then unmasked.
      ext_val = 8'hF7;
      tick(6);
      ext_val = 8'hF5;
      bus.addr = 3'd4;
      tick(S + 1);
      rd(3'd4, 8'h02, "fall_flag_set");
      chk("fall_masked_irq", 32'(irq), 32'h0);
      wr(3'd2, 8'h02);
      chk("mask_irq_lag", 32'(irq), 32'h0);
      tick(1);
      chk("mask_irq_set", 32'(irq), 32'h1);

      // Edge on bit2 lands on the same edge as its write-1-clear: set wins.
      wr(3'd4, 8'h02);
      ext_val = 8'hF1;
      tick(S);
      wr(3'd4, 8'h04);
      rd(3'd4, 8'h04, "set_beats_clear");

      // Async reset mid-operation with a flag pending and all bits driving.
      wr(3'd2, 8'h04);
      wr(3'd1, 8'hFF);
      tick(1);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      bus.addr = 3'd4;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_irq", 32'(irq), 32'h0);
      chk("async_rst_iflag", 32'(bus.data_out), 32'h0);
      ext_val = 8'h00;
      tick(1);
      rd(3'd5, 8'h00, "rst_pin_read");
      ext_val = 8'hAA;
      #2;
      ext_val = 8'hFF;
      tick(1);
      reset = 1'b0;

      // Rising polarity armed during priming: high pins must not flag.
      wr(3'd3, 8'hFF);
      wr(3'd2, 8'hFF);
      tick(10);
      rd(3'd4, 8'h00, "prime_no_flag");
      chk("prime_irq", 32'(irq), 32'h0);
      ext_val = 8'hDF;
      tick(6);
      ext_val = 8'hFF;
      bus.addr = 3'd4;
      tick(S + 1);
      rd(3'd4, 8'h20, "post_prime_rise");
      tick(1);
      chk("post_prime_irq", 32'(irq), 32'h1);
      rd(3'd6, 8'h00, "addr6_zero");
      wr(3'd7, 8'h5A);
      rd(3'd7, 8'h00, "addr7_zero");
      tick(2);

      running = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
